// File: rtl/tx_arbiter_pkg.sv
// Shared definitions for the transmitter arbiter: FSM state encoding and default abort limit.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package tx_arbiter_pkg;

    // 2-bit FSM state encoding
    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_LAUNCH = 2'd1;
    localparam logic [1:0] ST_XMIT   = 2'd2;
    localparam logic [1:0] ST_DONE   = 2'd3;

    // Default per-transaction cycle budget before abort (timeout build only)
    localparam logic [15:0] TIMEOUT_DEFAULT = 16'd4000;

    typedef enum logic [1:0] {
        S_IDLE   = ST_IDLE,
        S_LAUNCH = ST_LAUNCH,
        S_XMIT   = ST_XMIT,
        S_DONE   = ST_DONE
    } state_t;

endpackage

// File: rtl/tx_arbiter_rr_picker.sv
// Round-robin picker: first asserted request at or after index (last+1) mod N_REQ.
// Latency: purely combinational, zero cycles.
// Backpressure: none; the result is sampled by the caller only when it grants.
// Ports: i_req (request vector), i_last (index served last),
//        o_pick (one-hot winner, all-zero when no request), o_pick_idx (winner index).
module rr_picker #(
    parameter int N_REQ = 4,
    parameter int IDX_W = 2
) (
    input  logic [N_REQ-1:0] i_req,
    input  logic [IDX_W-1:0] i_last,
    output logic [N_REQ-1:0] o_pick,
    output logic [IDX_W-1:0] o_pick_idx
);

    logic w_found;
    int   w_j;

    // Walk the ring starting just after the last winner; the first hit wins,
    // so the last winner itself is visited last (lowest priority).
    always_comb begin
        o_pick     = '0;
        o_pick_idx = '0;
        w_found    = 1'b0;
        w_j        = 0;
        for (int k = 1; k <= N_REQ; k++) begin
            w_j = (int'(i_last) + k) % N_REQ;
            if (!w_found && i_req[w_j]) begin
                w_found         = 1'b1;
                o_pick[w_j]     = 1'b1;
                o_pick_idx      = IDX_W'(w_j);
            end
        end
    end

endmodule

// File: rtl/tx_arbiter.sv
// Round-robin arbiter sharing one character transmitter among N_REQ requesters.
// Latency: grant one edge after a qualifying request in IDLE; min 4 cycles grant-to-grant.
// Backpressure: waits on tx_busy (must be low to grant, high to leave LAUNCH, low to finish).
// Ports: clk, rst_n (async active-low), en (gates new grants), req / req_data (per-requester
//        request and character slice), tx_busy (transmitter status), tx_start / tx_data (to
//        transmitter), gnt (one-hot, held through the transaction), done (1-cycle completion
//        pulse), arb_busy (not IDLE), err (1-cycle timeout pulse).
// Optional feature: define TX_ARB_TIMEOUT_EN to add the TIMEOUT parameter, the cycle counter
//        and the err port; without it LAUNCH and XMIT wait indefinitely.
module tx_arbiter
    import tx_arbiter_pkg::*;
#(
    parameter int N_REQ  = 4,
    parameter int DATA_W = 8
`ifdef TX_ARB_TIMEOUT_EN
    ,
    parameter logic [15:0] TIMEOUT = TIMEOUT_DEFAULT
`endif
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      en,
    input  logic [N_REQ-1:0]          req,
    input  logic [N_REQ*DATA_W-1:0]   req_data,
    input  logic                      tx_busy,
    output logic                      tx_start,
    output logic [DATA_W-1:0]         tx_data,
    output logic [N_REQ-1:0]          gnt,
    output logic [N_REQ-1:0]          done,
`ifdef TX_ARB_TIMEOUT_EN
    output logic                      err,
`endif
    output logic                      arb_busy
);

    localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    state_t              r_state;
    state_t              w_next;
    logic                w_grant;
    logic [N_REQ-1:0]    r_gnt;
    logic [N_REQ-1:0]    w_pick;
    logic [IDX_W-1:0]    r_idx;
    logic [IDX_W-1:0]    r_last;
    logic [IDX_W-1:0]    w_pick_idx;
    logic [DATA_W-1:0]   r_tx_data;
    logic [DATA_W-1:0]   w_sel_data;
`ifdef TX_ARB_TIMEOUT_EN
    logic [15:0]         r_cnt;
    logic                r_err;
    logic                w_timeout;
`endif

    rr_picker #(
        .N_REQ (N_REQ),
        .IDX_W (IDX_W)
    ) u_picker (
        .i_req      (req),
        .i_last     (r_last),
        .o_pick     (w_pick),
        .o_pick_idx (w_pick_idx)
    );

    // Character slice of the winning requester
    always_comb begin
        w_sel_data = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (w_pick[i]) begin
                w_sel_data = req_data[i*DATA_W +: DATA_W];
            end
        end
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state logic
    always_comb begin
        w_next  = r_state;
        w_grant = 1'b0;
`ifdef TX_ARB_TIMEOUT_EN
        w_timeout = 1'b0;
`endif
        case (r_state)
            // A busy transmitter (e.g. still finishing a foreign frame) holds off the grant
            S_IDLE: begin
                if (en && (|req) && !tx_busy) begin
                    w_grant = 1'b1;
                    w_next  = S_LAUNCH;
                end
            end
            S_LAUNCH: if (tx_busy)  w_next = S_XMIT;
            S_XMIT:   if (!tx_busy) w_next = S_DONE;
            S_DONE:   w_next = S_IDLE;
            default:  w_next = S_IDLE;
        endcase
`ifdef TX_ARB_TIMEOUT_EN
        // The counter holds the number of completed LAUNCH/XMIT cycles, so the abort
        // edge is the one closing the TIMEOUT-th cycle; it overrides normal progress.
        if (((r_state == S_LAUNCH) || (r_state == S_XMIT)) && (r_cnt == TIMEOUT - 16'd1)) begin
            w_timeout = 1'b1;
            w_next    = S_IDLE;
        end
`endif
    end

    // Grant, character and round-robin bookkeeping
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_gnt     <= '0;
            r_idx     <= '0;
            r_last    <= IDX_W'(N_REQ - 1);
            r_tx_data <= '0;
`ifdef TX_ARB_TIMEOUT_EN
            r_cnt     <= '0;
            r_err     <= 1'b0;
`endif
        end else begin
`ifdef TX_ARB_TIMEOUT_EN
            r_err <= 1'b0;
            if ((r_state == S_LAUNCH) || (r_state == S_XMIT)) begin
                r_cnt <= r_cnt + 16'd1;
            end
`endif
            if (w_grant) begin
                r_gnt     <= w_pick;
                r_idx     <= w_pick_idx;
                r_tx_data <= w_sel_data;
`ifdef TX_ARB_TIMEOUT_EN
                r_cnt     <= '0;
`endif
            end else if (r_state == S_DONE) begin
                r_gnt  <= '0;
                r_last <= r_idx;
            end
`ifdef TX_ARB_TIMEOUT_EN
            // An aborted requester also drops to lowest priority
            if (w_timeout) begin
                r_gnt  <= '0;
                r_last <= r_idx;
                r_err  <= 1'b1;
            end
`endif
        end
    end

    assign tx_start = (r_state == S_LAUNCH);
    assign tx_data  = r_tx_data;
    assign gnt      = r_gnt;
    assign done     = (r_state == S_DONE) ? r_gnt : '0;
    assign arb_busy = (r_state != S_IDLE);
`ifdef TX_ARB_TIMEOUT_EN
    assign err      = r_err;
`endif

endmodule

// File: doc/tx_arbiter.md
TX_ARBITER -- requirements
Module: tx_arbiter

Interface
REQ-001 Parameter N_REQ, default 4: number of requesters sharing the single transmitter.
REQ-002 Parameter DATA_W, default 8: character width, equal to the transmitter parallel input width.
REQ-003 Parameter TIMEOUT, default 16'd4000: clk cycles allowed per transaction before abort.
REQ-004 clk  input  1  rising-edge clock; the same clock that drives the transmitter.
REQ-005 rst_n  input  1  asynchronous, active-low reset.
REQ-006 en  input  1  arbitration enable; low blocks new grants only.
REQ-007 req  input  N_REQ  per-requester level request.
REQ-008 req_data  input  N_REQ*DATA_W  flat character bus; slice i belongs to requester i.
REQ-009 tx_busy  input  1  transmitter busy flag.
REQ-010 tx_start  output  1  start request to the transmitter.
REQ-011 tx_data  output  DATA_W  registered character presented to the transmitter.
REQ-012 gnt  output  N_REQ  one-hot grant, held for the whole transaction.
REQ-013 done  output  N_REQ  one-cycle completion pulse to the granted requester.
REQ-014 err  output  1  one-cycle timeout pulse; present only when the timeout feature is compiled in.
REQ-015 arb_busy  output  1  high in every state except IDLE.

Function
REQ-016 The FSM SHALL have the states IDLE, LAUNCH, XMIT and DONE.
REQ-017 IDLE: when en=1 and req!=0, the FSM SHALL select the first asserted req at or after index (last+1) mod N_REQ, set the corresponding gnt bit, latch req_data slice into tx_data, and enter LAUNCH on the next edge.
REQ-018 LAUNCH: tx_start SHALL be 1; the FSM SHALL move to XMIT on the first cycle tx_busy=1.
REQ-019 XMIT: tx_start SHALL be 0; the FSM SHALL move to DONE on the first cycle tx_busy=0.
REQ-020 DONE: done[g] SHALL be 1 for exactly one cycle, gnt SHALL clear, last SHALL be set to g, and the FSM SHALL return to IDLE.
REQ-021 The minimum time from grant to the next possible grant SHALL be 4 cycles (LAUNCH, XMIT, DONE, IDLE).
REQ-022 tx_data and gnt SHALL remain constant from grant until DONE; req_data changes after the grant SHALL be ignored.
REQ-023 A requester that still holds req after its done pulse SHALL re-compete at lowest priority.
REQ-024 Dropping req mid-transaction SHALL NOT abort the transaction; done SHALL still pulse.
REQ-025 en=0 mid-transaction SHALL NOT affect the transaction; only the next grant SHALL be blocked.
REQ-026 If tx_busy=1 while in IDLE, no grant SHALL be issued until tx_busy=0.
REQ-027 With a single requester continuously asserted, that requester SHALL be served back-to-back with no starvation of others: each asserted requester SHALL be served within N_REQ grants.

Reset
REQ-028 rst_n=0 SHALL immediately force IDLE, tx_start=0, tx_data=0, gnt=0, done=0, err=0, arb_busy=0, last=N_REQ-1 (so that index 0 wins first) and the timeout counter to 0.
REQ-029 Reset asserted mid-transaction SHALL abandon the transaction without a done or err pulse.

Configuration
REQ-030 Macro TX_ARB_TIMEOUT_EN defined: a counter SHALL clear on grant and increment in LAUNCH and XMIT; on reaching TIMEOUT, the block SHALL pulse err for one cycle, assert no done, clear gnt and tx_start, set last=g, and return to IDLE.
REQ-031 Macro TX_ARB_TIMEOUT_EN undefined: the err port and the counter SHALL be absent, and LAUNCH and XMIT SHALL wait indefinitely.

Structure
REQ-032 A shared package SHALL hold the FSM state encoding (2-bit localparams) and the default TIMEOUT value.
REQ-033 The round-robin selection SHALL be a sub-module rr_picker (req, last in; one-hot pick and its index out, purely combinational).

Verification
REQ-034 Single request: req=4'b0010, slice1=8'hA9, tx_busy goes high 3 cycles after tx_start and low 80 cycles later -> gnt=4'b0010, tx_data=8'hA9, one done[1] pulse, tx_start dropped on the cycle tx_busy rises.
REQ-035 Contention: req=4'b1111 held, each transaction completed -> grant order 0,1,2,3,0.
REQ-036 Priority rotation: after requester 2 is served, req=4'b0101 -> requester 0 is granted.
REQ-037 Timeout (TX_ARB_TIMEOUT_EN, TIMEOUT=10): tx_busy held 0 -> err pulses after 10 cycles in LAUNCH, no done, FSM returns to IDLE.
REQ-038 Reset mid-XMIT: rst_n pulsed low -> all outputs 0 at once; after release, req=4'b0001 -> requester 0 is granted.
REQ-039 en=0 with req=4'b0001 -> no grant; en raised -> grant on the next cycle.
